// File: rtl/param_updown_counter.sv
// param_updown_counter: up/down counter stepped by a programmable prescaler enable,
// with synchronous load, wrap/saturate limits and registered tick/tc pulses.
module param_updown_counter #(
    parameter int WIDTH     = 4,
    parameter int DIV_WIDTH = 3,
    parameter int SATURATE  = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div_ratio,
    input  logic                 mode,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     count,
    output logic                 tick,
    output logic                 tc
);
    logic [DIV_WIDTH-1:0] div_cnt;
    logic                 step;
    logic                 at_lim;
    logic [WIDTH-1:0]     nxt;
    // >= rather than == so a lowered div_ratio steps at once instead of wrapping div_cnt
    assign step   = en && (div_cnt >= div_ratio);
    assign at_lim = mode ? &count : ~|count;
    assign nxt    = (at_lim && SATURATE != 0) ? count : mode ? count + 1'b1 : count - 1'b1;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            count   <= '0;
            tick    <= 1'b0;
            tc      <= 1'b0;
        end else if (load) begin
            div_cnt <= '0;
            count   <= load_val;
            tick    <= 1'b0;
            tc      <= 1'b0;
        end else begin
            div_cnt <= step ? '0 : en ? div_cnt + 1'b1 : div_cnt;
            count   <= step ? nxt : count;
            tick    <= step;
            tc      <= step && at_lim;
        end
    end
endmodule

// File: tb/tb_param_updown_counter.sv
// tb_param_updown_counter: directed checks of a wrapping and a saturating counter
// against an integer reference model compared every cycle.
module tb_param_updown_counter;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       en = 1'b0;
    logic [2:0] div_ratio = 3'd0;
    logic       mode = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'h0;
    logic [3:0] count0, count1;
    logic       tick0, tick1, tc0, tc1;
    int         checks = 0;
    int         errors = 0;
    int         m_cnt[2];
    int         m_div[2];
    bit         m_tick[2];
    bit         m_tc[2];
    bit         m_step;

    param_updown_counter #(.WIDTH(4), .DIV_WIDTH(3), .SATURATE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en), .div_ratio(div_ratio), .mode(mode),
        .load(load), .load_val(load_val), .count(count0), .tick(tick0), .tc(tc0)
    );
    param_updown_counter #(.WIDTH(4), .DIV_WIDTH(3), .SATURATE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en), .div_ratio(div_ratio), .mode(mode),
        .load(load), .load_val(load_val), .count(count1), .tick(tick1), .tc(tc1)
    );

    always #5 clk = ~clk;

    // Reference model: counts in plain integers; index 0 wraps, index 1 clamps
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n) begin
                m_cnt[k] = 0; m_div[k] = 0; m_tick[k] = 0; m_tc[k] = 0;
            end else if (load) begin
                m_cnt[k] = int'(load_val); m_div[k] = 0; m_tick[k] = 0; m_tc[k] = 0;
            end else begin
                m_step = en && (m_div[k] >= int'(div_ratio));
                m_tick[k] = m_step;
                m_tc[k] = 0;
                if (m_step) begin
                    m_div[k] = 0;
                    if (mode) begin
                        if (m_cnt[k] == 15) begin m_tc[k] = 1; m_cnt[k] = (k == 1) ? 15 : 0; end
                        else m_cnt[k] = m_cnt[k] + 1;
                    end else begin
                        if (m_cnt[k] == 0) begin m_tc[k] = 1; m_cnt[k] = (k == 1) ? 0 : 15; end
                        else m_cnt[k] = m_cnt[k] - 1;
                    end
                end else if (en) m_div[k] = m_div[k] + 1;
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_count0", int'(count0), m_cnt[0]);
            check("model_tick0", int'(tick0), int'(m_tick[0]));
            check("model_tc0", int'(tc0), int'(m_tc[0]));
            check("model_count1", int'(count1), m_cnt[1]);
            check("model_tick1", int'(tick1), int'(m_tick[1]));
            check("model_tc1", int'(tc1), int'(m_tc[1]));
        end
    end

    task automatic clk1;
        @(posedge clk);
        #2;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #11;
        check("rst_count", int'(count0), 0);
        check("rst_tick", int'(tick0), 0);
        check("rst_tc", int'(tc0), 0);
        // 1: divide by 4, count up from reset
        en = 1'b1; mode = 1'b1; div_ratio = 3'd3; rst_n = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            clk1;
            check("t1_tick", int'(tick0), (i % 4 == 0) ? 1 : 0);
            check("t1_tc", int'(tc0), 0);
        end
        check("t1_count", int'(count0), 4);
        check("t1_count_sat", int'(count1), 4);
        // 2: wrap up through F and down through 0
        div_ratio = 3'd0; load = 1'b1; load_val = 4'hE;
        clk1; load = 1'b0;
        check("t2_load", int'(count0), 14);
        check("t2_load_tick", int'(tick0), 0);
        clk1; check("t2_f", int'(count0), 15); check("t2_f_tc", int'(tc0), 0);
        clk1; check("t2_wrap", int'(count0), 0); check("t2_wrap_tc", int'(tc0), 1);
        check("t2_clamp_sat", int'(count1), 15); check("t2_clamp_sat_tc", int'(tc1), 1);
        load = 1'b1; load_val = 4'h1; mode = 1'b0;
        clk1; load = 1'b0;
        check("t2_load1", int'(count0), 1);
        clk1; check("t2_zero", int'(count0), 0); check("t2_zero_tc", int'(tc0), 0);
        clk1; check("t2_dwrap", int'(count0), 15); check("t2_dwrap_tc", int'(tc0), 1);
        check("t2_dclamp_sat", int'(count1), 0);
        // 3: saturating clamps at both ends
        load = 1'b1; load_val = 4'hF; mode = 1'b1;
        clk1; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1;
            check("t3_up_count", int'(count1), 15);
            check("t3_up_tick", int'(tick1), 1);
            check("t3_up_tc", int'(tc1), 1);
        end
        check("t3_up_wrapcnt", int'(count0), 2);
        load = 1'b1; load_val = 4'h0; mode = 1'b0;
        clk1; load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            clk1;
            check("t3_dn_count", int'(count1), 0);
            check("t3_dn_tc", int'(tc1), 1);
        end
        // 4: load coincident with a step wins and restarts the prescaler
        div_ratio = 3'd3; mode = 1'b1; load = 1'b1; load_val = 4'h0;
        clk1; load = 1'b0;
        repeat (3) clk1;
        load = 1'b1; load_val = 4'h9;
        clk1; load = 1'b0;
        check("t4_count", int'(count0), 9);
        check("t4_tick", int'(tick0), 0);
        check("t4_tc", int'(tc0), 0);
        for (int i = 1; i <= 4; i++) begin
            clk1;
            check("t4_next_tick", int'(tick0), (i == 4) ? 1 : 0);
        end
        check("t4_next_count", int'(count0), 10);
        // 5: freeze with en low, then lower div_ratio below div_cnt
        div_ratio = 3'd7; load = 1'b1; load_val = 4'h0;
        clk1; load = 1'b0;
        repeat (5) clk1;
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            clk1;
            check("t5_frz_tick", int'(tick0), 0);
            check("t5_frz_count", int'(count0), 0);
        end
        div_ratio = 3'd2; en = 1'b1;
        clk1;
        check("t5_step_tick", int'(tick0), 1);
        check("t5_step_count", int'(count0), 1);
        // 6: asynchronous reset between edges
        clk1; clk1;
        rst_n = 1'b0;
        #1;
        check("t6_count", int'(count0), 0);
        check("t6_tick", int'(tick0), 0);
        check("t6_tc", int'(tc0), 0);
        check("t6_count_sat", int'(count1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        clk1; clk1;
        check("t6_hold", int'(count0), 0);
        clk1;
        check("t6_resume", int'(count0), 1);
        check("t6_resume_tick", int'(tick0), 1);
        repeat (2) clk1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
